// File: rtl/decode_center.sv
// Post-decode centering stage: streams RAM digits out as centered signed coefficients.
// Define DECODE_ROUNDED_EN to decode the Rounded format (c = 3r - HALFQ) instead of Rq.
module decode_center #(
  parameter int D_SIZE     = 13,
  parameter int DEPTH      = 10,
  parameter int P          = 761,
  parameter int Q          = 4591,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DEPTH-1:0]  cd_rd_addr,
  input  logic [D_SIZE-1:0] cd_rd_data,
  output logic [D_SIZE-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int W     = D_SIZE + 2;
  localparam int HALFQ = (Q - 1) / 2;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
`ifdef DECODE_ROUNDED_EN
  localparam int RLIM  = (Q + 2) / 3;
`else
  localparam int RLIM  = Q;
`endif
  localparam logic signed [W-1:0] HALFQ_W   = W'(HALFQ);
  localparam logic signed [W-1:0] RLIM_W    = W'(RLIM);
  localparam logic [DEPTH-1:0]    LAST_ADDR = DEPTH'(P - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  state_t              state_q, state_d;
  logic [DEPTH-1:0]    cd_rd_addr_q, cd_rd_addr_d;
  logic                vld1_q, vld1_d, last1_q, last1_d;
  logic                vld2_q, vld2_d, last2_q, last2_d;
  logic [D_SIZE-1:0]   conv_q, conv_d;
  logic                err_q, err_d;
  logic [CW-1:0]       count_q, count_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [D_SIZE:0]     mem_q [FIFO_DEPTH];
  logic [D_SIZE:0]     mem_d [FIFO_DEPTH];

  logic                credit_ok, issue, is_last_iss, push, pop, oor;
  logic [DEPTH-1:0]    iss_addr;
  logic [1:0]          inflight;
  logic signed [W-1:0] r_ext, diff;
  logic [D_SIZE-1:0]   conv_val;

  // Reads already issued but not yet in the FIFO count against its free space,
  // so a stalled consumer can never cause a push into a full FIFO.
  assign inflight    = {1'b0, vld1_q} + {1'b0, vld2_q};
  assign credit_ok   = (int'(count_q) + int'(inflight)) < FIFO_DEPTH;
  assign iss_addr    = (state_q == IDLE) ? '0 : cd_rd_addr_q + DEPTH'(1);
  assign is_last_iss = (iss_addr == LAST_ADDR);
  assign issue       = ((state_q == IDLE) && start) || ((state_q == READ) && credit_ok);
  assign push        = vld2_q;
  assign pop         = out_valid && out_ready;

  assign r_ext = signed'({2'b00, cd_rd_data});
`ifdef DECODE_ROUNDED_EN
  assign diff  = (r_ext <<< 1) + r_ext - HALFQ_W;
`else
  assign diff  = r_ext - HALFQ_W;
`endif
  // The digit compare guards against x3 wrap-around; the diff compare is exact for in-width values.
  assign oor      = (r_ext >= RLIM_W) || (diff > HALFQ_W);
  assign conv_val = oor ? HALFQ_W[D_SIZE-1:0] : diff[D_SIZE-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    if (issue && is_last_iss) state_d = DRAIN;
      DRAIN:   if (pop && out_last) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == FIN);
  end

  always_comb begin
    cd_rd_addr_d = issue ? iss_addr : cd_rd_addr_q;
    vld1_d       = issue;
    last1_d      = issue && is_last_iss;
    vld2_d       = vld1_q;
    last2_d      = last1_q;
    conv_d       = vld1_q ? conv_val : conv_q;
    err_d        = err_q;
    if ((state_q == IDLE) && start) begin
      err_d = 1'b0;
    end else if (vld1_q && oor) begin
      err_d = 1'b1;
    end
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = {last2_q, conv_q};
    end
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cd_rd_addr_q <= '0;
      vld1_q       <= 1'b0;
      last1_q      <= 1'b0;
      vld2_q       <= 1'b0;
      last2_q      <= 1'b0;
      conv_q       <= '0;
      err_q        <= 1'b0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cd_rd_addr_q <= cd_rd_addr_d;
      vld1_q       <= vld1_d;
      last1_q      <= last1_d;
      vld2_q       <= vld2_d;
      last2_q      <= last2_d;
      conv_q       <= conv_d;
      err_q        <= err_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_q        <= mem_d;
    end
  end

  assign cd_rd_addr = cd_rd_addr_q;
  assign err        = err_q;
  assign out_valid  = (count_q != '0);
  assign out_data   = mem_q[rd_ptr_q][D_SIZE-1:0];
  assign out_last   = out_valid && mem_q[rd_ptr_q][D_SIZE];

endmodule

// File: tb/tb_decode_center.sv
// Self-checking bench for decode_center: RAM model, output scoreboard, vector table.
module tb_decode_center;

  localparam int P     = 761;
  localparam int Q     = 4591;
  localparam int HALFQ = 2295;
  localparam int FD    = 4;
`ifdef DECODE_ROUNDED_EN
  localparam int RLIM  = (Q + 2) / 3;
`else
  localparam int RLIM  = Q;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, err, out_valid, out_ready, out_last;
  logic [9:0]  cd_rd_addr;
  logic [12:0] cd_rd_data, out_data;
  logic [12:0] ram [1024];

  decode_center #(.D_SIZE(13), .DEPTH(10), .P(P), .Q(Q), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .cd_rd_addr(cd_rd_addr), .cd_rd_data(cd_rd_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;
  assign cd_rd_data = ram[cd_rd_addr];

  typedef struct { int data; bit last; } exp_t;
  typedef struct { int pass_id; int idx; int r; int exp_c; } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   checks = 0;
  int   failures = 0;
  int   acc = 0;
  int   max_ahead = 0;
  int   out_cap [P];
  int   bp_mode = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  function automatic int model(input int r);
`ifdef DECODE_ROUNDED_EN
    return (r < RLIM) ? 3 * r - HALFQ : HALFQ;
`else
    return (r < RLIM) ? r - HALFQ : HALFQ;
`endif
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = (bp_mode != 0) ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // Scoreboard pop on each handshake; also tracks how far reads run ahead of accepts.
  always @(negedge clk) begin
    exp_t e;
    if (busy && (int'(cd_rd_addr) + 1 - acc > max_ahead))
      max_ahead = int'(cd_rd_addr) + 1 - acc;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("data[%0d]", acc), int'($signed(out_data)), e.data);
        chk($sformatf("last[%0d]", acc), int'(out_last), int'(e.last));
      end
      if (acc < P) out_cap[acc] = int'($signed(out_data));
      acc++;
    end
  end

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_valid"}, int'(out_valid), 0);
    chk({tag, "_last"}, int'(out_last), 0);
    chk({tag, "_addr"}, int'(cd_rd_addr), 0);
    chk({tag, "_data"}, int'(out_data), 0);
  endtask

  task automatic launch();
    acc = 0;
    max_ahead = 0;
    for (int i = 0; i < P; i++) sb.push_back('{model(int'(ram[i])), (i == P - 1)});
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_pass(input int exp_err, input bit timed);
    int n, first_v, done_n;
    launch();
    n = 0; first_v = -1; done_n = -1;
    while (n < 10000) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("busy_after_start", int'(busy), 1);
        chk("addr_after_start", int'(cd_rd_addr), 0);
        chk("err_cleared_by_start", int'(err), 0);
      end
      if (first_v < 0 && out_valid) first_v = n;
      if (done) begin
        done_n = n;
        break;
      end
    end
    if (done_n < 0) chk("done_timeout", 0, 1);
    chk("first_valid_cycle", first_v, 3);
    if (timed) chk("done_cycle", done_n, P + 3);
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
    chk("busy_after_done", int'(busy), 0);
    chk("err_after_pass", int'(err), exp_err);
    chk("sb_empty", sb.size(), 0);
    chk("accepted", acc, P);
    chk("addr_ahead_ok", int'(max_ahead <= FD), 1);
  endtask

  task automatic ramp();
    for (int i = 0; i < 1024; i++) ram[i] = 13'(i % Q);
  endtask

  task automatic apply_table(input int pid);
    for (int k = 0; k < 8; k++)
      if (vecs[k].pass_id == pid && vecs[k].r >= 0) ram[vecs[k].idx] = 13'(vecs[k].r);
  endtask

  task automatic check_table(input int pid);
    for (int k = 0; k < 8; k++)
      if (vecs[k].pass_id == pid)
        chk($sformatf("vec_c[%0d]", vecs[k].idx), out_cap[vecs[k].idx], vecs[k].exp_c);
  endtask

  initial begin
    int n;
`ifdef DECODE_ROUNDED_EN
    vecs[0] = '{1, 0,   -1,   -2295};
    vecs[1] = '{1, 300, -1,   -1395};
    vecs[2] = '{1, 760, -1,   -15};
    vecs[3] = '{2, 0,   1530, 2295};
    vecs[4] = '{2, 1,   765,  0};
    vecs[5] = '{2, 2,   1531, 2295};
    vecs[6] = '{2, 6,   8191, 2295};
    vecs[7] = '{2, 7,   1,    -2292};
`else
    vecs[0] = '{1, 0,   -1,   -2295};
    vecs[1] = '{1, 300, -1,   -1995};
    vecs[2] = '{1, 760, -1,   -1535};
    vecs[3] = '{2, 0,   4590, 2295};
    vecs[4] = '{2, 1,   0,    -2295};
    vecs[5] = '{2, 5,   4600, 2295};
    vecs[6] = '{2, 6,   4591, 2295};
    vecs[7] = '{2, 7,   2295, 0};
`endif
    ramp();
    repeat (3) @(negedge clk);
    chk_idle("in_reset");
    rst = 1'b0;
    @(negedge clk);
    chk_idle("after_reset");

    ramp();
    run_pass(0, 1'b1);
    check_table(1);

    ramp();
    apply_table(2);
    run_pass(1, 1'b1);
    check_table(2);

    for (int i = 0; i < 1024; i++) ram[i] = 13'($urandom_range(0, RLIM - 1));
    bp_mode = 1;
    run_pass(0, 1'b0);
    bp_mode = 0;

    ramp();
    launch();
    n = 0;
    while (acc < 300 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_300", int'(acc >= 300), 1);
    rst = 1'b1;
    #2;
    chk_idle("mid_reset");
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_idle("post_mid_reset");
    run_pass(0, 1'b1);
    check_table(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
